image_stream_source: RTL and testbench

Parametrised pixel streamer that feeds the first convolution layer. It holds one frame (IMG_H × IMG_W × CHANNELS samples) in an internal buffer loaded through a write port. On `start` it emits the frame in raster order over a valid/ready stream with row and frame markers, and it can optionally loop the frame continuously. It replaces free-running, index-driven pixel feeding with a back-pressurable source usable in both synthesis and bench.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/frame_buffer_ram.sv | 27 ++
 rtl/image_stream_source.sv | 200 ++++++++++++++++++++
 tb/tb_image_stream_source.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared defaults for the CNN input path and the pixel-streamer FSM encoding.
package cnn_pkg;

    localparam int unsigned CNN_DATA_W   = 8;
    localparam int unsigned CNN_IMG_W    = 28;
    localparam int unsigned CNN_IMG_H    = 28;
    localparam int unsigned CNN_CHANNELS = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } stream_state_e;

    // Width of a counter over 0..n-1, kept at least one bit wide.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module frame_buffer_ram #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 784,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/image_stream_source.sv
// Frame-buffered pixel streamer: raster-order valid/ready output with row
// and frame markers, optional continuous looping.
module image_stream_source
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W   = CNN_DATA_W,
    parameter int unsigned IMG_W    = CNN_IMG_W,
    parameter int unsigned IMG_H    = CNN_IMG_H,
    parameter int unsigned CHANNELS = CNN_CHANNELS,
    parameter int unsigned DEPTH    = IMG_W * IMG_H * CHANNELS,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic              start,
    input  logic              repeat_en,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_eol,
    output logic              m_last
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);
    localparam int unsigned CH_W  = cnt_w(CHANNELS);

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              rep_q, rep_d;
    logic              rd_vld_q, rd_eol_q, rd_last_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_eol_q, fifo_last_q;
    logic              wptr_q, rptr_q;
    logic [1:0]        count_q;
    logic              done_q, done_d, wr_drop_q;
    logic              issue, issue_eol, issue_last, room, pop, wr_ok;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = fifo_data_q[rptr_q];
    assign m_eol   = fifo_eol_q[rptr_q];
    assign m_last  = fifo_last_q[rptr_q];
    assign pop     = m_valid && m_ready;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign wr_drop = wr_drop_q;

    assign wr_ok = wr_en && (state_q == ST_IDLE) && (32'(wr_addr) < DEPTH);

    // A read may issue only if the skid buffer can still absorb it after
    // the beat already in flight, assuming no further pops.
    assign room = ({1'b0, count_q} + {2'b0, rd_vld_q} - {2'b0, pop}) <= 3'd1;

    assign issue_eol  = (col_q == COL_W'(IMG_W - 1)) && (ch_q == CH_W'(CHANNELS - 1));
    assign issue_last = (rd_ptr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        col_d    = col_q;
        row_d    = row_q;
        ch_d     = ch_q;
        rep_d    = rep_q;
        issue    = 1'b0;
        done_d   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_STREAM;
                        rd_ptr_d = '0;
                        col_d    = '0;
                        row_d    = '0;
                        ch_d     = '0;
                        rep_d    = repeat_en;
                    end
                end
                ST_STREAM: begin
                    if (room) begin
                        issue    = 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        if (ch_q == CH_W'(CHANNELS - 1)) begin
                            ch_d = '0;
                            if (col_q == COL_W'(IMG_W - 1)) begin
                                col_d = '0;
                                row_d = row_q + 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                        if (issue_last) begin
                            rd_ptr_d = '0;
                            col_d    = '0;
                            row_d    = '0;
                            ch_d     = '0;
                            if (!rep_q) begin
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            ch_q      <= '0;
            rep_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_eol_q  <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            rep_q     <= rep_d;
            rd_vld_q  <= issue;
            done_q    <= done_d;
            wr_drop_q <= wr_en && !wr_ok;
            if (issue) begin
                rd_eol_q  <= issue_eol;
                rd_last_q <= issue_last;
            end
        end
    end

    // Skid buffer: markers travel with the sample; abort drops everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_eol_q  <= '0;
            fifo_last_q <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= '0;
        end else if (abort) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (rd_vld_q) begin
                fifo_data_q[wptr_q] <= rd_data;
                fifo_eol_q[wptr_q]  <= rd_eol_q;
                fifo_last_q[wptr_q] <= rd_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_q + 2'(rd_vld_q) - 2'(pop);
        end
    end

    frame_buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (issue),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench for image_stream_source: default 28x28x1 frame plus a 4x2x3 instance.
module tb_image_stream_source;

    localparam int DEPTH   = 784;
    localparam int B_DEPTH = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr_en = 1'b0, start = 1'b0, repeat_en = 1'b0, abort = 1'b0, m_ready = 1'b1;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_drop, busy, done, m_valid, m_eol, m_last;
    logic [7:0] m_data;

    logic       b_wr_en = 1'b0, b_start = 1'b0, b_repeat_en = 1'b0, b_abort = 1'b0, b_m_ready = 1'b1;
    logic [4:0] b_wr_addr = '0;
    logic [7:0] b_wr_data = '0;
    logic       b_wr_drop, b_busy, b_done, b_m_valid, b_m_eol, b_m_last;
    logic [7:0] b_m_data;

    int errors = 0;
    int checks = 0;

    image_stream_source dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop), .start(start), .repeat_en(repeat_en), .abort(abort),
        .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_eol(m_eol), .m_last(m_last)
    );

    image_stream_source #(
        .DATA_W(8), .IMG_W(4), .IMG_H(2), .CHANNELS(3)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_drop(b_wr_drop), .start(b_start), .repeat_en(b_repeat_en), .abort(b_abort),
        .busy(b_busy), .done(b_done), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .m_eol(b_m_eol), .m_last(b_m_last)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic rep);
        start     = 1'b1;
        repeat_en = rep;
        tick();
        start     = 1'b0;
        repeat_en = 1'b0;
    endtask

    task automatic load_frame();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Consumes one full non-repeat frame starting at the first valid cycle.
    task automatic run_frame(input bit rand_ready, input string tag, output int cycles);
        int         k;
        logic [7:0] pd;
        logic       pe, pl, pstall;
        logic [7:0] exp_d;
        k = 0; cycles = 0; pstall = 1'b0; pd = '0; pe = 1'b0; pl = 1'b0;
        while (k < DEPTH && cycles < 10000) begin
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pstall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pd || m_eol !== pe || m_last !== pl) begin
                    errors++;
                    $display("FAIL %s_stall beat=%0d got v=%b d=%0d eol=%b last=%b want v=1 d=%0d eol=%b last=%b",
                             tag, k, m_valid, m_data, m_eol, m_last, pd, pe, pl);
                end
            end
            if (m_valid && m_ready) begin
                exp_d = 8'(k);
                checks++;
                if (m_data !== exp_d || m_eol !== ((k % 28) == 27) || m_last !== (k == DEPTH - 1)) begin
                    errors++;
                    $display("FAIL %s_beat idx=%0d got d=%0d eol=%b last=%b want d=%0d eol=%b last=%b",
                             tag, k, m_data, m_eol, m_last, exp_d, (k % 28) == 27, k == DEPTH - 1);
                end
                k++;
            end
            pstall = m_valid && !m_ready;
            pd = m_data; pe = m_eol; pl = m_last;
            tick();
            cycles++;
        end
        m_ready = 1'b1;
        checks++;
        if (k !== DEPTH) begin
            errors++;
            $display("FAIL %s_count got %0d beats want %0d", tag, k, DEPTH);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b want done=1 busy=0", tag, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse got done=%b want 0", tag, done);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({m_valid, m_data, m_eol, m_last, busy, done, wr_drop} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%0d eol=%b last=%b busy=%b done=%b drop=%b want all 0",
                     m_valid, m_data, m_eol, m_last, busy, done, wr_drop);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int cyc;
        do_start(1'b0);
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_edge got busy=%b valid=%b want busy=1 valid=0", busy, m_valid);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_plus1 got valid=%b want 0", m_valid);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd0) begin
            errors++;
            $display("FAIL first_beat got valid=%b d=%0d want valid=1 d=0", m_valid, m_data);
        end
        run_frame(1'b0, "stream", cyc);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL stream_gapless got %0d cycles want %0d", cyc, DEPTH);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_start(1'b0);
        tick();
        tick();
        run_frame(1'b1, "bp", cyc);
    endtask

    task automatic test_channels();
        int k, cyc;
        for (int i = 0; i < B_DEPTH; i++) begin
            b_wr_en   = 1'b1;
            b_wr_addr = 5'(i);
            b_wr_data = 8'(i + 16);
            tick();
        end
        b_wr_en = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        k = 0; cyc = 0;
        while (k < B_DEPTH && cyc < 200) begin
            if (b_m_valid) begin
                checks++;
                if (b_m_data !== 8'(k + 16) || b_m_eol !== (k == 11 || k == 23) || b_m_last !== (k == 23)) begin
                    errors++;
                    $display("FAIL ch3_beat idx=%0d got d=%0d eol=%b last=%b want d=%0d eol=%b last=%b",
                             k, b_m_data, b_m_eol, b_m_last, k + 16, k == 11 || k == 23, k == 23);
                end
                k++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (k !== B_DEPTH || b_done !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL ch3_end got beats=%0d done=%b busy=%b want beats=24 done=1 busy=0", k, b_done, b_busy);
        end
    endtask

    task automatic test_repeat();
        int         lastcnt;
        int         idx;
        logic [7:0] exp_d;
        lastcnt = 0;
        do_start(1'b1);
        tick();
        tick();
        for (int c = 0; c < 2000; c++) begin
            start = (c == 500);
            idx   = c % DEPTH;
            exp_d = 8'(idx);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d || m_last !== (idx == DEPTH - 1) || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL repeat_beat c=%0d got v=%b d=%0d last=%b done=%b busy=%b want v=1 d=%0d last=%b done=0 busy=1",
                         c, m_valid, m_data, m_last, done, busy, exp_d, idx == DEPTH - 1);
            end
            if (m_valid && m_last) lastcnt++;
            tick();
        end
        start = 1'b0;
        checks++;
        if (lastcnt !== 2) begin
            errors++;
            $display("FAIL repeat_last_count got %0d want 2", lastcnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL repeat_abort got v=%b busy=%b done=%b want 0 0 0", m_valid, busy, done);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_same got busy=%b want 0", busy);
        end
    endtask

    task automatic test_write_drop();
        int cyc;
        do_start(1'b0);
        wr_en   = 1'b1;
        wr_addr = 10'd5;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy got wr_drop=%b want 1", wr_drop);
        end
        tick();
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse got wr_drop=%b want 0", wr_drop);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stream got busy=%b v=%b done=%b want 0 0 0", busy, m_valid, done);
        end
        wr_en   = 1'b1;
        wr_addr = 10'd800;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_range got wr_drop=%b want 1", wr_drop);
        end
        wr_en   = 1'b1;
        wr_addr = 10'd5;
        wr_data = 8'd5;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL write_ok got wr_drop=%b want 0", wr_drop);
        end
        do_start(1'b0);
        tick();
        tick();
        run_frame(1'b0, "after_drop", cyc);
    endtask

    task automatic test_reset_mid();
        int k, cyc;
        k = 0; cyc = 0;
        do_start(1'b0);
        while (cyc < 400 && !(m_valid && k == 100)) begin
            if (m_valid && m_ready) k++;
            tick();
            cyc++;
        end
        checks++;
        if (k !== 100) begin
            errors++;
            $display("FAIL reset_mid_reach got %0d beats want 100", k);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, m_data, m_eol, m_last, busy, done, wr_drop} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got v=%b d=%0d eol=%b last=%b busy=%b done=%b drop=%b want all 0",
                     m_valid, m_data, m_eol, m_last, busy, done, wr_drop);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got busy=%b v=%b want 0 0", busy, m_valid);
        end
        do_start(1'b0);
        tick();
        tick();
        run_frame(1'b0, "after_reset", cyc);
    endtask

    initial begin
        test_reset();
        load_frame();
        test_stream();
        test_backpressure();
        test_channels();
        test_repeat();
        test_write_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
